// File: rtl/gsensor_sequencer.sv
// gsensor_sequencer: schedules SPI engine transactions for an ADXL345.
// Issues a three-write init sequence after reset, then periodic 6-byte burst
// reads of the X/Y/Z registers, with host register writes arbitrated in
// between. Received bytes are assembled into signed 16-bit samples.
module gsensor_sequencer #(
    parameter int CLK_FREQUENCY    = 50_000_000,
    parameter int UPDATE_FREQUENCY = 50
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               spi_req,
    input  logic               spi_ack,
    output logic               spi_read,
    output logic [5:0]         spi_addr,
    output logic [2:0]         spi_len,
    output logic [7:0]         spi_wdata,
    input  logic               spi_rdata_valid,
    input  logic [7:0]         spi_rdata,
    input  logic               spi_done,
    input  logic               cfg_req,
    input  logic [5:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic               cfg_ack,
    output logic               init_done,
    output logic               data_valid,
    output logic signed [15:0] data_x,
    output logic signed [15:0] data_y,
    output logic signed [15:0] data_z,
    output logic               overrun
);

    localparam int PERIOD  = CLK_FREQUENCY / UPDATE_FREQUENCY;
    localparam int TIMER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PERIOD - 1);

    localparam logic [5:0] DATA_ADDR  = 6'h32;
    localparam logic [2:0] READ_LEN   = 3'd6;
    localparam logic [2:0] WRITE_LEN  = 3'd1;
    localparam logic [1:0] INIT_LAST  = 2'd2;
    localparam logic [2:0] RX_BYTES   = 3'd6;
    localparam logic [2:0] RX_CNT_MAX = 3'd7;

    typedef enum logic [2:0] {
        INIT_ISSUE = 3'd0,
        INIT_WAIT  = 3'd1,
        IDLE       = 3'd2,
        RD_ISSUE   = 3'd3,
        RD_WAIT    = 3'd4,
        WR_ISSUE   = 3'd5,
        WR_WAIT    = 3'd6
    } state_t;

    // Init table: data format (3-wire, +-2g), 50 Hz output rate, measure mode.
    function automatic logic [5:0] init_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return 6'h31;
            2'd1:    return 6'h2C;
            default: return 6'h2D;
        endcase
    endfunction

    function automatic logic [7:0] init_data(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h40;
            2'd1:    return 8'h09;
            default: return 8'h08;
        endcase
    endfunction

    // The device sends the low byte first; samples are {high, low}.
    function automatic logic signed [15:0] pack_word(input logic [7:0] hi,
                                                     input logic [7:0] lo);
        return $signed({hi, lo});
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           init_idx_q, init_idx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 read_pending_q, read_pending_d;
    logic                 overrun_q, overrun_d;
    logic                 init_done_q, init_done_d;
    logic                 spi_req_q, spi_req_d;
    logic                 spi_read_q, spi_read_d;
    logic [5:0]           spi_addr_q, spi_addr_d;
    logic [2:0]           spi_len_q, spi_len_d;
    logic [7:0]           spi_wdata_q, spi_wdata_d;
    logic                 cfg_ack_q, cfg_ack_d;
    logic [5:0]           cfg_addr_lat_q, cfg_addr_lat_d;
    logic [7:0]           cfg_wdata_lat_q, cfg_wdata_lat_d;
    logic [2:0]           rx_cnt_q, rx_cnt_d;
    logic                 data_valid_q, data_valid_d;
    logic signed [15:0]   data_x_q, data_x_d;
    logic signed [15:0]   data_y_q, data_y_d;
    logic signed [15:0]   data_z_q, data_z_d;
    logic [7:0]           rx_q [6];
    logic [7:0]           rx_d [6];

    logic tick;
    logic req_accepted;
    logic rd_accept;

    // Next-state logic: timer, pending/overrun flags, byte capture and the FSM.
    always_comb begin
        state_d         = state_q;
        init_idx_d      = init_idx_q;
        timer_d         = timer_q;
        read_pending_d  = read_pending_q;
        overrun_d       = overrun_q;
        init_done_d     = init_done_q;
        spi_req_d       = spi_req_q;
        spi_read_d      = spi_read_q;
        spi_addr_d      = spi_addr_q;
        spi_len_d       = spi_len_q;
        spi_wdata_d     = spi_wdata_q;
        cfg_ack_d       = 1'b0;
        cfg_addr_lat_d  = cfg_addr_lat_q;
        cfg_wdata_lat_d = cfg_wdata_lat_q;
        rx_cnt_d        = rx_cnt_q;
        rx_d            = rx_q;
        data_valid_d    = 1'b0;
        data_x_d        = data_x_q;
        data_y_d        = data_y_q;
        data_z_d        = data_z_q;

        // The engine only acknowledges a request that is actually asserted.
        req_accepted = spi_req_q && spi_ack;
        rd_accept    = (state_q == RD_ISSUE) && req_accepted;

        // Update timer runs only after init; its wrap is the read tick.
        tick = init_done_q && (timer_q == TIMER_LAST);
        if (init_done_q) begin
            timer_d = tick ? '0 : timer_q + TIMER_W'(1);
        end

        // A tick landing on the accept cycle re-arms the next read rather
        // than counting as an overrun, since the previous one was taken.
        if (tick) begin
            read_pending_d = 1'b1;
        end else if (rd_accept) begin
            read_pending_d = 1'b0;
        end
        if (tick && read_pending_q && !rd_accept) begin
            overrun_d = 1'b1;
        end

        // Keep the first six bytes; the counter saturates so a long burst
        // is still distinguishable from an exact one.
        if ((state_q == RD_WAIT) && spi_rdata_valid) begin
            if (rx_cnt_q < RX_BYTES) begin
                rx_d[rx_cnt_q] = spi_rdata;
            end
            if (rx_cnt_q != RX_CNT_MAX) begin
                rx_cnt_d = rx_cnt_q + 3'd1;
            end
        end

        case (state_q)
            INIT_ISSUE: begin
                if (req_accepted) begin
                    spi_req_d = 1'b0;
                    state_d   = INIT_WAIT;
                end else begin
                    spi_req_d   = 1'b1;
                    spi_read_d  = 1'b0;
                    spi_addr_d  = init_addr(init_idx_q);
                    spi_len_d   = WRITE_LEN;
                    spi_wdata_d = init_data(init_idx_q);
                end
            end
            INIT_WAIT: begin
                if (spi_done) begin
                    if (init_idx_q == INIT_LAST) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        state_d    = INIT_ISSUE;
                    end
                end
            end
            IDLE: begin
                // A tick in this very cycle already counts as pending, so a
                // host request arriving alongside it still loses to the read.
                // The host drops cfg_req only after seeing cfg_ack, so the
                // ack cycle itself must not start another write.
                if (read_pending_q || tick) begin
                    state_d = RD_ISSUE;
                end else if (cfg_req && init_done_q && !cfg_ack_q) begin
                    cfg_addr_lat_d  = cfg_addr;
                    cfg_wdata_lat_d = cfg_wdata;
                    state_d         = WR_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (req_accepted) begin
                    spi_req_d = 1'b0;
                    rx_cnt_d  = 3'd0;
                    state_d   = RD_WAIT;
                end else begin
                    spi_req_d   = 1'b1;
                    spi_read_d  = 1'b1;
                    spi_addr_d  = DATA_ADDR;
                    spi_len_d   = READ_LEN;
                    spi_wdata_d = 8'h00;
                end
            end
            RD_WAIT: begin
                if (spi_done) begin
                    state_d = IDLE;
                    if (rx_cnt_d == RX_BYTES) begin
                        data_valid_d = 1'b1;
                        data_x_d     = pack_word(rx_d[1], rx_d[0]);
                        data_y_d     = pack_word(rx_d[3], rx_d[2]);
                        data_z_d     = pack_word(rx_d[5], rx_d[4]);
                    end
                end
            end
            WR_ISSUE: begin
                if (req_accepted) begin
                    spi_req_d = 1'b0;
                    state_d   = WR_WAIT;
                end else begin
                    spi_req_d   = 1'b1;
                    spi_read_d  = 1'b0;
                    spi_addr_d  = cfg_addr_lat_q;
                    spi_len_d   = WRITE_LEN;
                    spi_wdata_d = cfg_wdata_lat_q;
                end
            end
            WR_WAIT: begin
                if (spi_done) begin
                    cfg_ack_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and registered outputs, synchronously cleared by reset_n.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= INIT_ISSUE;
            init_idx_q      <= 2'd0;
            timer_q         <= '0;
            read_pending_q  <= 1'b0;
            overrun_q       <= 1'b0;
            init_done_q     <= 1'b0;
            spi_req_q       <= 1'b0;
            spi_read_q      <= 1'b0;
            spi_addr_q      <= 6'd0;
            spi_len_q       <= 3'd0;
            spi_wdata_q     <= 8'd0;
            cfg_ack_q       <= 1'b0;
            cfg_addr_lat_q  <= 6'd0;
            cfg_wdata_lat_q <= 8'd0;
            rx_cnt_q        <= 3'd0;
            data_valid_q    <= 1'b0;
            data_x_q        <= '0;
            data_y_q        <= '0;
            data_z_q        <= '0;
        end else begin
            state_q         <= state_d;
            init_idx_q      <= init_idx_d;
            timer_q         <= timer_d;
            read_pending_q  <= read_pending_d;
            overrun_q       <= overrun_d;
            init_done_q     <= init_done_d;
            spi_req_q       <= spi_req_d;
            spi_read_q      <= spi_read_d;
            spi_addr_q      <= spi_addr_d;
            spi_len_q       <= spi_len_d;
            spi_wdata_q     <= spi_wdata_d;
            cfg_ack_q       <= cfg_ack_d;
            cfg_addr_lat_q  <= cfg_addr_lat_d;
            cfg_wdata_lat_q <= cfg_wdata_lat_d;
            rx_cnt_q        <= rx_cnt_d;
            data_valid_q    <= data_valid_d;
            data_x_q        <= data_x_d;
            data_y_q        <= data_y_d;
            data_z_q        <= data_z_d;
        end
    end

    // Raw byte buffer; only published through data_x/y/z, so no reset needed.
    always_ff @(posedge clk) begin
        rx_q <= rx_d;
    end

    assign spi_req    = spi_req_q;
    assign spi_read   = spi_read_q;
    assign spi_addr   = spi_addr_q;
    assign spi_len    = spi_len_q;
    assign spi_wdata  = spi_wdata_q;
    assign cfg_ack    = cfg_ack_q;
    assign init_done  = init_done_q;
    assign data_valid = data_valid_q;
    assign data_x     = data_x_q;
    assign data_y     = data_y_q;
    assign data_z     = data_z_q;
    assign overrun    = overrun_q;

endmodule
